// File: rtl/vdp_cpu_port_if.sv
// rtl/vdp_cpu_port_if.sv - Z80 I/O bus between CPU and VDP port
interface vdp_cpu_port_if;
    logic       cpu_wr;
    logic       cpu_rd;
    logic       cpu_port;
    logic [7:0] cpu_di;
    logic [7:0] cpu_do;

    modport master (output cpu_wr, output cpu_rd, output cpu_port, output cpu_di, input  cpu_do);
    modport slave  (input  cpu_wr, input  cpu_rd, input  cpu_port, input  cpu_di, output cpu_do);
endinterface

// File: rtl/vdp_cpu_port.sv
// rtl/vdp_cpu_port.sv - VDP CPU port: data/control decode, VRAM/CRAM writer, registers 0-10
module vdp_cpu_port #(
    parameter int VRAM_AW = 14,
    parameter int CRAM_AW = 5
) (
    input  logic               clk,
    input  logic               rst,
    vdp_cpu_port_if.slave      bus,
    output logic [VRAM_AW-1:0] o_vram_addr,
    output logic               o_vram_we,
    output logic [7:0]         o_vram_do,
    input  logic [7:0]         i_vram_di,
    output logic               o_cram_we,
    output logic [CRAM_AW-1:0] o_cram_addr,
    output logic [11:0]        o_cram_data,
    input  logic               i_frame_start,
    input  logic               i_vblank_pend,
    input  logic               i_line_pend,
    input  logic               i_spr_ovf,
    input  logic               i_spr_coll,
    output logic               o_status_clr,
    output logic               o_irq,
    output logic [7:0]         o_scroll_x,
    output logic [7:0]         o_scroll_y,
    output logic [2:0]         o_name_table_base,
    output logic               o_disable_x_scroll,
    output logic               o_disable_y_scroll,
    output logic               o_display_en,
    output logic [7:0]         o_line_reload
);
    localparam logic [VRAM_AW-1:0] ADDR_ONE = {{(VRAM_AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_PREFETCH, S_CAPTURE} state_t;

    state_t             r_state, w_state_nxt;
    logic [VRAM_AW-1:0] r_addr;
    logic [1:0]         r_code;
    logic               r_flag;
    logic [7:0]         r_rbuf;
    logic [7:0]         r_latch;
    logic [7:0]         r_regs [0:10];
    logic [7:0]         r_cpu_do;
    logic [VRAM_AW-1:0] r_vram_addr;
    logic               r_vram_we;
    logic [7:0]         r_vram_do;
    logic               r_cram_we;
    logic [CRAM_AW-1:0] r_cram_addr;
    logic [11:0]        r_cram_data;
    logic               r_clr_req;
    logic               r_status_clr;
    logic               r_irq;
    logic [7:0]         r_scroll_y;

    logic w_ctrl_wr, w_data_wr, w_ctrl_rd, w_data_rd, w_pf_start, w_capture;
    logic w_unused;

    // A simultaneous write strobe masks the read.
    assign w_ctrl_wr  = bus.cpu_wr & bus.cpu_port;
    assign w_data_wr  = bus.cpu_wr & ~bus.cpu_port;
    assign w_ctrl_rd  = bus.cpu_rd & ~bus.cpu_wr & bus.cpu_port;
    assign w_data_rd  = bus.cpu_rd & ~bus.cpu_wr & ~bus.cpu_port;
    assign w_pf_start = w_data_rd | (w_ctrl_wr & r_flag & (bus.cpu_di[7:6] == 2'd0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_pf_start) begin
            w_state_nxt = S_PREFETCH;
        end else begin
            case (r_state)
                S_PREFETCH: w_state_nxt = S_CAPTURE;
                S_CAPTURE:  w_state_nxt = S_IDLE;
                default:    w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_capture = 1'b0;
        if (r_state == S_CAPTURE) w_capture = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= '0;
            r_code       <= '0;
            r_flag       <= 1'b0;
            r_rbuf       <= '0;
            r_latch      <= '0;
            for (int i = 0; i < 11; i++) r_regs[i] <= '0;
            r_cpu_do     <= '0;
            r_vram_addr  <= '0;
            r_vram_we    <= 1'b0;
            r_vram_do    <= '0;
            r_cram_we    <= 1'b0;
            r_cram_addr  <= '0;
            r_cram_data  <= '0;
            r_clr_req    <= 1'b0;
            r_status_clr <= 1'b0;
            r_irq        <= 1'b0;
            r_scroll_y   <= '0;
        end else begin
            r_vram_we    <= 1'b0;
            r_cram_we    <= 1'b0;
            r_clr_req    <= w_ctrl_rd;
            r_status_clr <= r_clr_req;
            r_irq        <= (i_vblank_pend & r_regs[1][5]) | (i_line_pend & r_regs[0][4]);
            if (i_frame_start) r_scroll_y <= r_regs[9];

            // vram_addr was presented one clock earlier, so vram_di now holds that byte.
            if (w_capture) begin
                r_rbuf <= i_vram_di;
                r_addr <= r_addr + ADDR_ONE;
            end

            if (w_ctrl_wr) begin
                if (!r_flag) begin
                    r_addr[7:0] <= bus.cpu_di;
                    r_flag      <= 1'b1;
                end else begin
                    r_addr[VRAM_AW-1:8] <= bus.cpu_di[VRAM_AW-9:0];
                    r_code              <= bus.cpu_di[7:6];
                    r_flag              <= 1'b0;
                    if (bus.cpu_di[7:6] == 2'd0)
                        r_vram_addr <= {bus.cpu_di[VRAM_AW-9:0], r_addr[7:0]};
                    if ((bus.cpu_di[7:6] == 2'd2) && (bus.cpu_di[3:0] < 4'd11))
                        r_regs[bus.cpu_di[3:0]] <= r_addr[7:0];
                end
            end else if (w_data_wr) begin
                r_flag <= 1'b0;
                r_rbuf <= bus.cpu_di;
                r_addr <= r_addr + ADDR_ONE;
                if (r_code != 2'd3) begin
                    r_vram_we   <= 1'b1;
                    r_vram_addr <= r_addr;
                    r_vram_do   <= bus.cpu_di;
                end else if (!r_addr[0]) begin
                    r_latch <= bus.cpu_di;
                end else begin
                    r_cram_we   <= 1'b1;
                    r_cram_addr <= r_addr[CRAM_AW:1];
                    r_cram_data <= {bus.cpu_di[3:0], r_latch};
                end
            end else if (w_data_rd) begin
                r_cpu_do    <= r_rbuf;
                r_flag      <= 1'b0;
                r_vram_addr <= r_addr;
            end else if (w_ctrl_rd) begin
                r_cpu_do <= {i_vblank_pend, i_spr_ovf, i_spr_coll, 5'b0};
                r_flag   <= 1'b0;
            end
        end
    end

    assign bus.cpu_do         = r_cpu_do;
    assign o_vram_addr        = r_vram_addr;
    assign o_vram_we          = r_vram_we;
    assign o_vram_do          = r_vram_do;
    assign o_cram_we          = r_cram_we;
    assign o_cram_addr        = r_cram_addr;
    assign o_cram_data        = r_cram_data;
    assign o_status_clr       = r_status_clr;
    assign o_irq              = r_irq;
    assign o_scroll_x         = r_regs[8];
    assign o_scroll_y         = r_scroll_y;
    assign o_name_table_base  = r_regs[2][3:1];
    assign o_disable_x_scroll = r_regs[0][6];
    assign o_disable_y_scroll = r_regs[0][7];
    assign o_display_en       = r_regs[1][6];
    assign o_line_reload      = r_regs[10];

    // Registers 3-7 and the undecoded bits are held for the CPU's benefit only.
    assign w_unused = ^{r_regs[0], r_regs[1], r_regs[2], r_regs[3], r_regs[4],
                        r_regs[5], r_regs[6], r_regs[7]};
endmodule
